cart_rom_server: RTL and testbench

- Responder side of the cartridge ROM fetch interface driven by the console core.
- Accepts byte read strobes plus a 25-bit byte address from the core and returns the byte on cart_out.
- Serves each read from a small word buffer, or fetches a 16-bit word from the external SDRAM-style memory port over a req/ack handshake.
- Sits between the core's cart_read/cart_addr_out/cart_out signals and the memory controller.

---
 rtl/cart_rom_server.sv | 213 +++++++++++++++++++++
 tb/tb_cart_rom_server.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_rom_server.sv
// Cartridge ROM byte server: answers core byte reads from a word buffer or an SDRAM word fetch.
// Latency: hit/out-of-range 1 cycle, miss 2 + memory ack delay; optional next-word prefetch via CART_PREFETCH_EN.
// Backpressure: none toward the core; reads arriving while busy go to a one-deep pending slot (last wins, sets overrun).
module cart_rom_server #(
    parameter int         ADDR_W   = 25,
    parameter logic [7:0] OOR_DATA = 8'hFF
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              cart_read,
    input  logic [ADDR_W-1:0] cart_addr,
    input  logic [31:0]       cart_size,
    input  logic              invalidate,
    output logic [7:0]        cart_out,
    output logic              cart_valid,
    output logic              busy,
    output logic              overrun,
    output logic              mem_req,
    output logic [ADDR_W-2:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata
);

    localparam int WW = ADDR_W - 1;
`ifdef CART_PREFETCH_EN
    localparam int NE = 2;
`else
    localparam int NE = 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FETCH    = 2'd1,
        S_PREFETCH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NE-1:0]     valid_q, valid_d;
    logic [WW-1:0]     tag_q  [NE];
    logic [WW-1:0]     tag_d  [NE];
    logic [15:0]       data_q [NE];
    logic [15:0]       data_d [NE];
    logic              pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [WW-1:0]     mem_addr_q, mem_addr_d;
    logic              lsb_q, lsb_d;
    logic [7:0]        cart_out_q, cart_out_d;
    logic              cart_valid_q, cart_valid_d;
    logic              overrun_q, overrun_d;

    // Entry currently being filled; the single-entry build always fills entry 0.
    logic [0:0]        fill_idx;
`ifdef CART_PREFETCH_EN
    logic [0:0]        fill_idx_q, fill_idx_d;
    logic [0:0]        last_q, last_d;
    logic [0:0]        hit_idx;
    logic [WW-1:0]     nxt_word;
    assign fill_idx = fill_idx_q;
    assign nxt_word = mem_addr_q + 1'b1;
`else
    assign fill_idx = 1'b0;
`endif

    logic [ADDR_W-1:0] req_addr;
    logic [WW-1:0]     req_word;
    logic              req_oor;
    logic              hit;
    logic [7:0]        hit_byte;

    // Classify the request seen in IDLE: the pending slot takes priority over a live strobe.
    always_comb begin
        req_addr = pend_vld_q ? pend_addr_q : cart_addr;
        req_word = req_addr[ADDR_W-1:1];
        req_oor  = 32'(req_addr) >= cart_size;
        hit      = 1'b0;
        hit_byte = 8'h00;
`ifdef CART_PREFETCH_EN
        hit_idx  = 1'b0;
`endif
        for (int i = 0; i < NE; i++) begin
            if (valid_q[i] && !invalidate && tag_q[i] == req_word) begin
                hit      = 1'b1;
                hit_byte = req_addr[0] ? data_q[i][15:8] : data_q[i][7:0];
`ifdef CART_PREFETCH_EN
                hit_idx  = 1'(i);
`endif
            end
        end
    end

    // Next-state logic: request handling in IDLE, fill and completion while a fetch is outstanding.
    always_comb begin
        state_d      = state_q;
        valid_d      = invalidate ? '0 : valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        pend_vld_d   = pend_vld_q;
        pend_addr_d  = pend_addr_q;
        mem_addr_d   = mem_addr_q;
        lsb_d        = lsb_q;
        cart_out_d   = cart_out_q;
        cart_valid_d = 1'b0;
        overrun_d    = overrun_q;
`ifdef CART_PREFETCH_EN
        fill_idx_d   = fill_idx_q;
        last_d       = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pend_vld_q || cart_read) begin
                    // Pending slot is consumed now, so a simultaneous live read simply refills it.
                    if (pend_vld_q) begin
                        pend_vld_d  = cart_read;
                        pend_addr_d = cart_addr;
                    end
                    if (req_oor) begin
                        cart_out_d   = OOR_DATA;
                        cart_valid_d = 1'b1;
                    end else if (hit) begin
                        cart_out_d   = hit_byte;
                        cart_valid_d = 1'b1;
`ifdef CART_PREFETCH_EN
                        last_d       = hit_idx;
`endif
                    end else begin
                        state_d    = S_FETCH;
                        mem_addr_d = req_word;
                        lsb_d      = req_addr[0];
`ifdef CART_PREFETCH_EN
                        fill_idx_d = ~last_q;
`endif
                    end
                end
            end
            default: begin
                // Any read while a fetch is outstanding (including the ack cycle) is parked.
                if (cart_read) begin
                    pend_vld_d  = 1'b1;
                    pend_addr_d = cart_addr;
                    overrun_d   = overrun_q | pend_vld_q;
                end
                if (mem_ack) begin
                    for (int i = 0; i < NE; i++) begin
                        if (i == int'(fill_idx)) begin
                            data_d[i]  = mem_rdata;
                            tag_d[i]   = mem_addr_q;
                            valid_d[i] = !invalidate;
                        end
                    end
                    state_d = S_IDLE;
                    if (state_q == S_FETCH) begin
                        cart_out_d   = lsb_q ? mem_rdata[15:8] : mem_rdata[7:0];
                        cart_valid_d = 1'b1;
`ifdef CART_PREFETCH_EN
                        last_d = fill_idx_q;
                        // Skip the prefetch at the top word (no wrap) and past the end of the ROM.
                        if (mem_addr_q != '1 && 32'({nxt_word, 1'b0}) < cart_size) begin
                            state_d    = S_PREFETCH;
                            mem_addr_d = nxt_word;
                            fill_idx_d = ~fill_idx_q;
                        end
`endif
                    end
                end
            end
        endcase
    end

    // State registers; reset abandons any outstanding fetch and clears the buffer.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            tag_q        <= '{default: '0};
            data_q       <= '{default: '0};
            pend_vld_q   <= 1'b0;
            pend_addr_q  <= '0;
            mem_addr_q   <= '0;
            lsb_q        <= 1'b0;
            cart_out_q   <= 8'h00;
            cart_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef CART_PREFETCH_EN
            fill_idx_q   <= 1'b0;
            last_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            pend_vld_q   <= pend_vld_d;
            pend_addr_q  <= pend_addr_d;
            mem_addr_q   <= mem_addr_d;
            lsb_q        <= lsb_d;
            cart_out_q   <= cart_out_d;
            cart_valid_q <= cart_valid_d;
            overrun_q    <= overrun_d;
`ifdef CART_PREFETCH_EN
            fill_idx_q   <= fill_idx_d;
            last_q       <= last_d;
`endif
        end
    end

    assign cart_out   = cart_out_q;
    assign cart_valid = cart_valid_q;
    assign busy       = (state_q == S_FETCH);
    assign overrun    = overrun_q;
    assign mem_req    = (state_q != S_IDLE);
    assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_cart_rom_server.sv
// Directed bench for cart_rom_server (default single-entry build).
// Drives inputs 1ns after each rising edge and samples outputs at the same point.
// Table vectors cover hits and range boundaries; hand sequences cover fetch, pending, invalidate and reset.
module tb_cart_rom_server;

    logic        clk_sys;
    logic        reset_n;
    logic        cart_read;
    logic [24:0] cart_addr;
    logic [31:0] cart_size;
    logic        invalidate;
    logic [7:0]  cart_out;
    logic        cart_valid;
    logic        busy;
    logic        overrun;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    cart_rom_server dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .cart_read  (cart_read),
        .cart_addr  (cart_addr),
        .cart_size  (cart_size),
        .invalidate (invalidate),
        .cart_out   (cart_out),
        .cart_valid (cart_valid),
        .busy       (busy),
        .overrun    (overrun),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        rd;
        logic [24:0] addr;
        logic [31:0] size;
        logic        ev;
        logic [7:0]  eo;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Ack after dly further cycles, starting from a cycle where mem_req is visible.
    task automatic serve(input int dly, input logic [15:0] d);
        repeat (dly) tick();
        mem_ack   = 1'b1;
        mem_rdata = d;
        tick();
        mem_ack   = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        cart_read  = 1'b0;
        cart_addr  = '0;
        cart_size  = 32'h8000;
        invalidate = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;

        // Word 8 holds 16'hBEEF when the table runs.
        vecs[0]  = '{1'b1, 25'h0000011, 32'h00008000, 1'b1, 8'hBE};
        vecs[1]  = '{1'b1, 25'h0000010, 32'h00008000, 1'b1, 8'hEF};
        vecs[2]  = '{1'b0, 25'h0000000, 32'h00008000, 1'b0, 8'hEF};
        vecs[3]  = '{1'b1, 25'h0008000, 32'h00008000, 1'b1, 8'hFF};
        vecs[4]  = '{1'b1, 25'h0000011, 32'h00008000, 1'b1, 8'hBE};
        vecs[5]  = '{1'b1, 25'h1FFFFFF, 32'h00008000, 1'b1, 8'hFF};
        vecs[6]  = '{1'b1, 25'h0000011, 32'h00000011, 1'b1, 8'hFF};
        vecs[7]  = '{1'b1, 25'h0000010, 32'h00000011, 1'b1, 8'hEF};
        vecs[8]  = '{1'b0, 25'h0000000, 32'h00008000, 1'b0, 8'hEF};
        vecs[9]  = '{1'b1, 25'h0000011, 32'h00000000, 1'b1, 8'hFF};
        vecs[10] = '{1'b1, 25'h0000011, 32'h00008000, 1'b1, 8'hBE};
        vecs[11] = '{1'b1, 25'h0000010, 32'hFFFFFFFF, 1'b1, 8'hEF};

        // Reset state
        repeat (3) tick();
        chk("rst_cart_out", cart_out, 8'h00);
        chk("rst_cart_valid", cart_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        reset_n = 1'b1;
        tick();

        // First miss: read 0x10, ack 3 cycles after mem_req, cart_valid at cycle 5
        cart_read = 1'b1;
        cart_addr = 25'h10;
        tick();
        cart_read = 1'b0;
        chk("miss_req", mem_req, 1'b1);
        chk("miss_busy", busy, 1'b1);
        chk("miss_addr", mem_addr, 24'h8);
        chk("miss_valid_c1", cart_valid, 1'b0);
        repeat (3) tick();
        chk("miss_valid_c4", cart_valid, 1'b0);
        chk("miss_req_c4", mem_req, 1'b1);
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        chk("miss_valid_c5", cart_valid, 1'b1);
        chk("miss_out", cart_out, 8'hEF);
        chk("miss_req_done", mem_req, 1'b0);
        chk("miss_busy_done", busy, 1'b0);

        // Table: hits, holds and out-of-range boundaries against word 8
        for (int i = 0; i < 12; i++) begin
            cart_read = vecs[i].rd;
            cart_addr = vecs[i].addr;
            cart_size = vecs[i].size;
            tick();
            chk($sformatf("vec%0d_valid", i), cart_valid, vecs[i].ev);
            chk($sformatf("vec%0d_out", i), cart_out, vecs[i].eo);
            chk($sformatf("vec%0d_req", i), mem_req, 1'b0);
        end
        cart_read = 1'b0;
        cart_size = 32'h8000;
        tick();

        // Pending overwrite: 0x100 then 0x200 during a fetch; only 0x200 is served
        cart_read = 1'b1;
        cart_addr = 25'h40;
        tick();
        chk("ovr_req", mem_req, 1'b1);
        chk("ovr_addr", mem_addr, 24'h20);
        cart_addr = 25'h100;
        tick();
        chk("ovr_flag_one", overrun, 1'b0);
        cart_addr = 25'h200;
        tick();
        cart_read = 1'b0;
        chk("ovr_flag", overrun, 1'b1);
        serve(0, 16'h1234);
        chk("ovr_first_valid", cart_valid, 1'b1);
        chk("ovr_first_out", cart_out, 8'h34);
        tick();
        chk("ovr_second_req", mem_req, 1'b1);
        chk("ovr_second_addr", mem_addr, 24'h100);
        chk("ovr_second_busy", busy, 1'b1);
        serve(1, 16'h5678);
        chk("ovr_second_valid", cart_valid, 1'b1);
        chk("ovr_second_out", cart_out, 8'h78);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("ovr_idle%0d_req", i), mem_req, 1'b0);
            chk($sformatf("ovr_idle%0d_valid", i), cart_valid, 1'b0);
        end

        // Read in the ack cycle is pended, then hits back to back
        cart_read = 1'b1;
        cart_addr = 25'h10;
        tick();
        cart_read = 1'b0;
        chk("ackrd_req", mem_req, 1'b1);
        chk("ackrd_addr", mem_addr, 24'h8);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        cart_read = 1'b1;
        cart_addr = 25'h11;
        tick();
        mem_ack   = 1'b0;
        cart_read = 1'b0;
        chk("ackrd_fill_valid", cart_valid, 1'b1);
        chk("ackrd_fill_out", cart_out, 8'hEF);
        tick();
        chk("ackrd_hit_valid", cart_valid, 1'b1);
        chk("ackrd_hit_out", cart_out, 8'hBE);
        chk("ackrd_hit_req", mem_req, 1'b0);
        tick();
        chk("ackrd_quiet_valid", cart_valid, 1'b0);

        // Invalidate pulse turns the next read of word 8 into a miss
        cart_read = 1'b1;
        cart_addr = 25'h10;
        tick();
        cart_read = 1'b0;
        chk("inv_prehit_valid", cart_valid, 1'b1);
        chk("inv_prehit_req", mem_req, 1'b0);
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        cart_read  = 1'b1;
        cart_addr  = 25'h10;
        tick();
        cart_read = 1'b0;
        chk("inv_miss_req", mem_req, 1'b1);
        chk("inv_miss_valid", cart_valid, 1'b0);
        // Fill completing under invalidate returns data but leaves the entry invalid
        invalidate = 1'b1;
        serve(2, 16'hCAFE);
        chk("inv_fill_valid", cart_valid, 1'b1);
        chk("inv_fill_out", cart_out, 8'hFE);
        invalidate = 1'b0;
        tick();
        cart_read = 1'b1;
        cart_addr = 25'h11;
        tick();
        cart_read = 1'b0;
        chk("inv_refetch_req", mem_req, 1'b1);
        serve(0, 16'hCAFE);
        chk("inv_refetch_out", cart_out, 8'hCA);

        // Reset mid-fetch drops mem_req at once; late acks are ignored
        tick();
        cart_read = 1'b1;
        cart_addr = 25'h30;
        tick();
        cart_read = 1'b0;
        chk("rstf_req_before", mem_req, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rstf_req", mem_req, 1'b0);
        chk("rstf_busy", busy, 1'b0);
        chk("rstf_out", cart_out, 8'h00);
        chk("rstf_overrun", overrun, 1'b0);
        chk("rstf_valid", cart_valid, 1'b0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        reset_n = 1'b1;
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 16'h9999;
        tick();
        mem_ack = 1'b0;
        chk("rstf_late_valid", cart_valid, 1'b0);
        chk("rstf_late_req", mem_req, 1'b0);
        chk("rstf_late_out", cart_out, 8'h00);
        tick();
        chk("rstf_late_valid2", cart_valid, 1'b0);
        // Buffer was cleared by reset: word 8 misses again
        cart_read = 1'b1;
        cart_addr = 25'h10;
        tick();
        cart_read = 1'b0;
        chk("rstf_miss_req", mem_req, 1'b1);
        chk("rstf_miss_addr", mem_addr, 24'h8);
        serve(0, 16'hBEEF);
        chk("rstf_miss_out", cart_out, 8'hEF);
        chk("rstf_miss_valid", cart_valid, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
